image_burster: RTL and testbench

IMAGE_BURSTER -- requirements
Module: image_burster

---
 rtl/image_burster.sv | 206 ++++++++++++++++++++
 tb/tb_image_burster.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_burster.sv
// -----------------------------------------------------------------------------
// image_burster
//
// Collects a stream of single samples into two ping-pong image banks and,
// once a bank holds a complete image, replays it as one contiguous burst of
// THROUGHPUT-wide beats. The source may then refill the bank it just freed.
//
// Parameters
//   NO_CH          bits per sample (I/Q sign bits)
//   LOG2_IMG_SIZE  log2 of samples per image
//   THROUGHPUT     samples per output beat (power of 2, <= image size / 4)
//   GAP_CYC        minimum idle cycles between output bursts (0..15)
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous, active-low reset
//   in_vld    input sample valid
//   in_rdy    block can accept a sample this cycle (register decode only)
//   in_data   one sample
//   vld_out   beat valid (registered)
//   data_out  beat lanes [THROUGHPUT-1:0]; lane j of beat k = sample k*T+j
//   fill_lvl  number of banks holding a complete, unread image (0..2)
// -----------------------------------------------------------------------------
module image_burster #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int GAP_CYC       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [NO_CH-1:0] in_data,
  output logic             vld_out,
  output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
  output logic [1:0]       fill_lvl
);

  localparam int AW       = LOG2_IMG_SIZE;
  localparam int IMG_SIZE = 2 ** AW;
  localparam int NBEATS   = IMG_SIZE / THROUGHPUT;
  localparam int BW       = $clog2(NBEATS);
  localparam int SH       = $clog2(THROUGHPUT);

  localparam logic [BW-1:0] BEAT_LAST = BW'(NBEATS - 1);
  localparam logic [3:0]    GAP_LAST  = 4'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NO_CH-1:0] mem_q [2][IMG_SIZE];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_cnt_q, wr_cnt_d;

  state_t           state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [3:0]       gap_q, gap_d;

  logic             vld_out_q;
  logic [NO_CH-1:0] data_out_q [THROUGHPUT-1:0];

  logic             xfer;
  logic             last_wr;
  logic             emit;
  logic             release_rd;
  logic [AW-1:0]    rd_base;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign in_rdy  = ~full_q[wr_bank_q];
  assign xfer    = in_vld & in_rdy;
  assign last_wr = xfer && (wr_cnt_q == '1);

  // NOTE: image storage is deliberately left out of reset; a bank is only ever
  // read after it has been completely rewritten, so its power-up contents
  // never reach the outputs and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM and bank bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    emit       = 1'b0;
    release_rd = 1'b0;

    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (full_q[rd_bank_q]) begin
          state_d = BURST;
        end
      end

      BURST: begin
        emit = 1'b1;
        if (beat_q == BEAT_LAST) begin
          beat_d     = '0;
          release_rd = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          if (GAP_CYC == 0) begin
            // No gap required: chain straight into the other bank if it is
            // already complete, so back-to-back images stay bubble-free.
            state_d = full_q[~rd_bank_q] ? BURST : IDLE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          // rd_bank_q already points at the next bank; skipping IDLE here
          // keeps the spacing at exactly GAP_CYC idle cycles.
          state_d = full_q[rd_bank_q] ? BURST : IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The banks being freed and filled on one edge are always different: the
  // read bank is full while the write bank is not.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (xfer) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (release_rd) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (last_wr) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
  end

  assign rd_base = AW'(beat_q) << SH;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      beat_q    <= '0;
      gap_q     <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      vld_out_q <= 1'b0;
      for (int j = 0; j < THROUGHPUT; j++) begin
        data_out_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      vld_out_q <= emit;
      // data_out holds its last beat whenever no beat is emitted.
      if (emit) begin
        for (int j = 0; j < THROUGHPUT; j++) begin
          data_out_q[j] <= mem_q[rd_bank_q][rd_base + AW'(j)];
        end
      end
    end
  end

  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;
  assign fill_lvl = 2'(full_q[0]) + 2'(full_q[1]);

endmodule

// File: tb/tb_image_burster.sv
// -----------------------------------------------------------------------------
// tb_image_burster
//
// Two instances: dut_a (NO_CH=2, 16-sample images, THROUGHPUT=2, GAP_CYC=2)
// and dut_b (same image size, THROUGHPUT=1, GAP_CYC=0). Samples accepted by
// the DUT are pushed to a per-instance queue; a negedge monitor pops them as
// beats appear and also tracks burst lengths and idle spacing.
// -----------------------------------------------------------------------------
module tb_image_burster;

  logic       clk;
  logic       rst_a, rst_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic [1:0] din_a, din_b;
  logic       vout_a, vout_b;
  logic [1:0] dout_a [1:0];
  logic [1:0] dout_b [0:0];
  logic [1:0] fill_a, fill_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  // monitor-owned state
  int run_a = 0, idle_a = 0, bursts_a = 0;
  bit seen_a = 0;
  int run_b = 0;
  int runs_b[$];

  // bench-owned knobs read by the monitor
  int exp_gap_a  = -1;
  int gap_from_a = 0;

  image_burster #(.NO_CH(2), .LOG2_IMG_SIZE(4), .THROUGHPUT(2), .GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst_a), .in_vld(vld_a), .in_rdy(rdy_a), .in_data(din_a),
    .vld_out(vout_a), .data_out(dout_a), .fill_lvl(fill_a)
  );

  image_burster #(.NO_CH(2), .LOG2_IMG_SIZE(4), .THROUGHPUT(1), .GAP_CYC(0)) dut_b (
    .clk(clk), .rst(rst_b), .in_vld(vld_b), .in_rdy(rdy_b), .in_data(din_b),
    .vld_out(vout_b), .data_out(dout_b), .fill_lvl(fill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one sample; it is pushed to the scoreboard only once in_rdy is seen
  // high, so the following rising edge is the transfer. Returns at that edge.
  task automatic send(input bit sel, input logic [1:0] s, output int stalls);
    stalls = 0;
    @(negedge clk);
    if (sel) begin vld_b = 1'b1; din_b = s; end
    else     begin vld_a = 1'b1; din_a = s; end
    while (!(sel ? rdy_b : rdy_a) && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 50) begin
      check(sel ? "b_send_timeout" : "a_send_timeout", stalls, 0);
    end else begin
      if (sel) q_b.push_back(s);
      else     q_a.push_back(s);
      @(posedge clk);
    end
  endtask

  task automatic stop(input bit sel);
    #1;
    if (sel) vld_b = 1'b0;
    else     vld_a = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (sel ? (q_b.size() == 0 && !vout_b && run_b == 0)
              : (q_a.size() == 0 && !vout_a && run_a == 0)) break;
    end
    check(sel ? "b_drain_timeout" : "a_drain_timeout", i < 300, 1'b1);
    check(sel ? "b_sb_left" : "a_sb_left", sel ? q_b.size() : q_a.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_a) begin
      run_a  = 0;
      idle_a = 0;
      seen_a = 0;
    end else begin
      if (fill_a == 2'd2) check("a_rdy_both_full", rdy_a, 1'b0);
      if (vout_a) begin
        if (run_a == 0 && seen_a) begin
          check("a_gap_min", idle_a >= 2, 1'b1);
          if (exp_gap_a >= 0 && bursts_a > gap_from_a) check("a_gap_exact", idle_a, exp_gap_a);
        end
        for (int j = 0; j < 2; j++) begin
          if (q_a.size() == 0) check("a_sb_empty", 0, 1);
          else check("a_lane", dout_a[j], q_a.pop_front());
        end
        run_a++;
      end else begin
        if (run_a != 0) begin
          check("a_burst_len", run_a, 8);
          bursts_a++;
          seen_a = 1;
          idle_a = 0;
          run_a  = 0;
        end
        idle_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      run_b = 0;
    end else if (vout_b) begin
      if (q_b.size() == 0) check("b_sb_empty", 0, 1);
      else check("b_lane", dout_b[0], q_b.pop_front());
      run_b++;
    end else if (run_b != 0) begin
      runs_b.push_back(run_b);
      run_b = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int stl;
    vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    // reset, before any clock edge
    check("a_rst_vld",  vout_a, 1'b0);
    check("a_rst_d0",   dout_a[0], 2'd0);
    check("a_rst_d1",   dout_a[1], 2'd0);
    check("a_rst_rdy",  rdy_a, 1'b1);
    check("a_rst_fill", fill_a, 2'd0);
    check("b_rst_vld",  vout_b, 1'b0);
    check("b_rst_d0",   dout_b[0], 2'd0);
    check("b_rst_rdy",  rdy_b, 1'b1);
    check("b_rst_fill", fill_b, 2'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // single image, sample n = n mod 4
    for (int n = 0; n < 16; n++) send(0, 2'(n % 4), stl);
    stop(0);
    @(negedge clk);
    check("a_single_c1_vld",  vout_a, 1'b0);
    check("a_single_fill1",   fill_a, 2'd1);
    check("a_single_rdy",     rdy_a, 1'b1);
    @(negedge clk);
    check("a_single_c2_vld",  vout_a, 1'b0);
    @(negedge clk);
    check("a_single_c3_vld",  vout_a, 1'b1);
    drain(0);
    check("a_single_fill0",   fill_a, 2'd0);
    check("a_hold_lane0",     dout_a[0], 2'd2);
    check("a_hold_lane1",     dout_a[1], 2'd3);

    // three images back to back; reader waits on the writer, so spacing is 8
    gap_from_a = bursts_a;
    exp_gap_a  = 8;
    for (int n = 0; n < 48; n++) send(0, 2'($urandom_range(0, 3)), stl);
    stop(0);
    drain(0);
    exp_gap_a = -1;
    check("a_b2b_bursts", bursts_a - gap_from_a, 3);
    check("a_b2b_fill0",  fill_a, 2'd0);

    // bursty input at ~50% density
    for (int n = 0; n < 32; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        stop(0);
        @(posedge clk);
      end
      send(0, 2'($urandom_range(0, 3)), stl);
    end
    stop(0);
    drain(0);

    // reset mid-burst with a partial second image in flight
    for (int n = 0; n < 16; n++) send(0, 2'($urandom_range(0, 3)), stl);
    for (int n = 0; n < 3; n++)  send(0, 2'($urandom_range(0, 3)), stl);
    stop(0);
    begin
      int i;
      for (i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (run_a >= 4) break;
      end
      check("a_rst_wait", run_a >= 4, 1'b1);
    end
    rst_a = 1'b0;
    #1;
    check("a_mid_rst_vld",  vout_a, 1'b0);
    check("a_mid_rst_fill", fill_a, 2'd0);
    check("a_mid_rst_rdy",  rdy_a, 1'b1);
    check("a_mid_rst_d0",   dout_a[0], 2'd0);
    q_a.delete();
    @(negedge clk);
    #1 rst_a = 1'b1;
    for (int n = 0; n < 16; n++) send(0, 2'($urandom_range(0, 3)), stl);
    stop(0);
    drain(0);
    check("a_post_rst_fill", fill_a, 2'd0);

    // THROUGHPUT=1, GAP_CYC=0: two images stream gap-free, third stalls once
    for (int n = 0; n < 32; n++) send(1, 2'($urandom_range(0, 3)), stl);
    #1;
    check("b_both_full_rdy",  rdy_b, 1'b0);
    check("b_both_full_fill", fill_b, 2'd2);
    send(1, 2'($urandom_range(0, 3)), stl);
    check("b_stall_cycles", stl, 1);
    #1;
    check("b_refill_fill", fill_b, 2'd1);
    for (int n = 1; n < 16; n++) send(1, 2'($urandom_range(0, 3)), stl);
    stop(1);
    drain(1);
    check("b_runs", runs_b.size(), 2);
    if (runs_b.size() == 2) begin
      check("b_run0_len", runs_b[0], 32);
      check("b_run1_len", runs_b[1], 16);
    end
    check("b_fill0", fill_b, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
